// File: rtl/pattern_tx_0011.sv
// Framed serial transmitter: sync pattern 0011, MSB-first payload, optional parity, guard bit.
// Define PATTERN_TX_PARITY_EN to insert an even-parity bit between payload and guard.
module pattern_tx_0011 #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              w,
  output logic              busy,
  output logic              bit_tick,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef PATTERN_TX_PARITY_EN
    PAR,
`endif
    GUARD
  } state_t;

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0]  SYNC_LAST = 4'd3;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [3:0]        idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              w_n, done_n;
`ifdef PATTERN_TX_PARITY_EN
  logic              par, par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      w     <= 1'b1;
      done  <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      w     <= w_n;
      done  <= done_n;
`ifdef PATTERN_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // w is registered: the value chosen here is the bit for the period that starts next cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    w_n     = w;
    done_n  = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        w_n = 1'b1;
        if (start) begin
          shreg_n = data_in;
`ifdef PATTERN_TX_PARITY_EN
          par_n   = ^data_in;
`endif
          cnt_n   = CNT_LAST;
          idx_n   = '0;
          w_n     = 1'b0;
          state_n = SYNC;
        end
      end
      default: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          cnt_n = CNT_LAST;
          idx_n = '0;
          case (state)
            SYNC: begin
              if (idx == SYNC_LAST) begin
                state_n = DATA;
                w_n     = shreg[DATA_W-1];
                shreg_n = shreg << 1;
              end else begin
                idx_n = idx + 4'd1;
                w_n   = (idx >= 4'd1);
              end
            end
            DATA: begin
              if (idx == IDX_LAST) begin
`ifdef PATTERN_TX_PARITY_EN
                state_n = PAR;
                w_n     = par;
`else
                state_n = GUARD;
                w_n     = 1'b1;
`endif
              end else begin
                idx_n   = idx + 4'd1;
                w_n     = shreg[DATA_W-1];
                shreg_n = shreg << 1;
              end
            end
`ifdef PATTERN_TX_PARITY_EN
            PAR: begin
              state_n = GUARD;
              w_n     = 1'b1;
            end
`endif
            GUARD: begin
              state_n = IDLE;
              w_n     = 1'b1;
              done_n  = 1'b1;
              cnt_n   = '0;
            end
            default: begin
              state_n = IDLE;
              w_n     = 1'b1;
              cnt_n   = '0;
            end
          endcase
        end
      end
    endcase
  end

  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE);
  assign bit_tick = busy && (cnt == CNT_LAST);

endmodule

// File: tb/tb_pattern_tx_0011.sv
// Bench for pattern_tx_0011: DIV=4 instance checked by a scoreboard, DIV=1 instance checked inline.
module tb_pattern_tx_0011;

  localparam int DW = 8;
  localparam int DV = 4;
`ifdef PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F  = (4 + DW + P + 1) * DV;
  localparam int F1 = 4 + DW + P + 1;

  logic clk = 1'b0;
  logic rst;
  logic start = 1'b0, start1 = 1'b0;
  logic [DW-1:0] data_in = '0, data1 = '0;
  logic ready, w, busy, bit_tick, done;
  logic ready1, w1, busy1, bit_tick1, done1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int det_cnt = 0;
  logic [3:0] det_sh = 4'b1111;

  pattern_tx_0011 #(.DATA_W(DW), .DIV(DV)) u0 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready), .w(w), .busy(busy), .bit_tick(bit_tick), .done(done)
  );

  pattern_tx_0011 #(.DATA_W(DW), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .ready(ready1), .w(w1), .busy(busy1), .bit_tick(bit_tick1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 0011 detector on the DIV=1 line
  always @(negedge clk) begin
    det_sh = {det_sh[2:0], w1};
    if (det_sh == 4'b0011) det_cnt++;
  end

  // Scoreboard model of the DIV=4 instance
  logic exp_bits[$];
  int   mrem = 0;
  logic mdone = 1'b0;
  logic cur_bit = 1'b1;
  logic exp_tick, exp_w;

  always @(negedge clk) begin
    if (rst) begin
      mrem = 0;
      mdone = 1'b0;
      exp_bits.delete();
    end
    exp_tick = (mrem != 0) && (((F - mrem) % DV) == 0);
    if (exp_tick) begin
      if (exp_bits.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: queue empty at cyc %0d", cyc);
      end else begin
        cur_bit = exp_bits.pop_front();
      end
    end
    exp_w = (mrem == 0) ? 1'b1 : cur_bit;
    total++;
    if (ready !== (mrem == 0)) begin bad++; $display("FAIL sb_ready: got %b want %b cyc %0d", ready, (mrem == 0), cyc); end
    total++;
    if (busy !== (mrem != 0)) begin bad++; $display("FAIL sb_busy: got %b want %b cyc %0d", busy, (mrem != 0), cyc); end
    total++;
    if (bit_tick !== exp_tick) begin bad++; $display("FAIL sb_tick: got %b want %b cyc %0d", bit_tick, exp_tick, cyc); end
    total++;
    if (done !== mdone) begin bad++; $display("FAIL sb_done: got %b want %b cyc %0d", done, mdone, cyc); end
    total++;
    if (w !== exp_w) begin bad++; $display("FAIL sb_w: got %b want %b cyc %0d", w, exp_w, cyc); end
    if (done === 1'b1) done_cnt++;
    if (mrem != 0) begin
      mrem--;
      mdone = (mrem == 0);
    end else begin
      mdone = 1'b0;
      if (start && !rst) begin
        exp_bits.push_back(1'b0); exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
        for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(data_in[i]);
`ifdef PATTERN_TX_PARITY_EN
        exp_bits.push_back(^data_in);
`endif
        exp_bits.push_back(1'b1);
        mrem = F;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    @(posedge clk); #1;
    data_in = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ready, w, busy, done, bit_tick} !== 5'b11000) begin
      bad++; $display("FAIL reset_outputs: got %b want 11000", {ready, w, busy, done, bit_tick});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame(input logic [DW-1:0] d, input string name);
    int a;
    bit ok;
    send(d);
    a = cyc;
    wait_done(F + 10, name, ok);
    if (ok) begin
      total++;
      if (cyc - a != F) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, cyc - a, F); end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int d0, c1;
    bit ok;
    d0 = done_cnt;
    @(posedge clk); #1;
    data_in = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h00;
    wait_done(F + 10, "b2b_first", ok);
    c1 = cyc;
    total++;
    if ({ready, done} !== 2'b11) begin bad++; $display("FAIL b2b_boundary: got ready,done=%b want 11", {ready, done}); end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: busy got %b want 1", busy); end
    wait_done(F + 10, "b2b_second", ok);
    if (ok) begin
      total++;
      if (cyc - c1 != F + 1) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - c1, F + 1); end
    end
    repeat (3) @(posedge clk);
    total++;
    if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_ignore_busy();
    int d0;
    bit ok;
    d0 = done_cnt;
    send(8'hA5);
    repeat (6 * DV) @(posedge clk);
    #1;
    data_in = 8'h3C;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(F + 10, "ignore", ok);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_second: busy got %b want 0", busy); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    send(8'hA5);
    repeat (6 * DV + 1) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({w, ready, busy, bit_tick, done} !== 5'b11000) begin
      bad++; $display("FAIL rst_mid_abort: got %b want 11000", {w, ready, busy, bit_tick, done});
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (F + 5) @(posedge clk);
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, d0); end
    test_frame(8'h3C, "after_rst");
  endtask

  task automatic test_div1();
    logic b[$];
    int d0;
    b = {1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = DW - 1; i >= 0; i--) b.push_back(data1_val(i));
`ifdef PATTERN_TX_PARITY_EN
    b.push_back(1'b0);
`endif
    b.push_back(1'b1);
    d0 = det_cnt;
    @(posedge clk); #1;
    data1 = 8'hA5;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < F1; i++) begin
      @(negedge clk);
      total++;
      if ({bit_tick1, busy1, w1} !== {1'b1, 1'b1, b[i]}) begin
        bad++; $display("FAIL div1_bit%0d: got tick,busy,w=%b want %b", i, {bit_tick1, busy1, w1}, {1'b1, 1'b1, b[i]});
      end
    end
    @(negedge clk);
    total++;
    if ({done1, ready1, bit_tick1, w1} !== 4'b1101) begin
      bad++; $display("FAIL div1_end: got done,ready,tick,w=%b want 1101", {done1, ready1, bit_tick1, w1});
    end
    repeat (5) @(posedge clk);
    total++;
    if (det_cnt - d0 != 1) begin bad++; $display("FAIL div1_detector: got %0d want 1", det_cnt - d0); end
  endtask

  function automatic logic data1_val(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

  initial begin
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h01, "frame_01");
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
